lzrw1_decomp_sched: RTL and testbench
=====================================

# lzrw1_decomp_sched

Sequencer that feeds `decompressor_top` from a packed LZRW1 compressed stream. It accepts 16-bit words from an upstream source: a control word, then up to 16 items that the control word describes. It unpacks the control bits, issues one item at a time under the decompressor's busy handshake, counts emitted bytes, and reports completion. It sits between the compressed-data buffer/DMA and the `decompressor_top` instance.

## Interface
Parameters:
- `MAX_ITEMS`, 4096: maximum items per job.
- `CNT_W`, `$clog2(MAX_ITEMS+1)`: item counter width (13 by default).
- `TIMEOUT_CYCLES`, 1024: busy watchdog limit; used only with `LZRW1_SCHED_TIMEOUT_EN`.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: begin job; sampled in IDLE only.
- `num_items`  in  CNT_W: item count for the job; latched on `start`.
- `in_word`  in  16: upstream stream (control word or item).
- `in_valid`  in  1: `in_word` valid.
- `in_ready`  out  1: word consumed when `in_valid & in_ready`.
- `dec_data_in`  out  16: to decompressor `data_in`.
- `dec_control_word_in`  out  1: to decompressor `control_word_in` (1 = copy item, 0 = literal).
- `dec_data_in_valid`  out  1: to decompressor `data_in_valid`.
- `dec_busy`  in  1: from decompressor `decompressor_busy`.
- `dec_out_valid`  in  1: from decompressor `out_valid`.
- `byte_count`  out  16: decompressed bytes seen this job; saturates at 16'hFFFF.
- `sched_busy`  out  1: high from `start` until the job ends.
- `done`  out  1: level; set at job end, cleared by the next accepted `start`.
- `error`  out  1: watchdog fired; cleared by the next accepted `start`.

## Operation
- States: IDLE, LOAD_CW, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE + `start`:
  - `num_items==0`: go to FINISH.
  - Otherwise: latch `num_items` into `items_left`, clear `byte_count`, `done` and `error`, then go to LOAD_CW.
- LOAD_CW:
  - `in_ready=1`.
  - On handshake, load the control word into the shift register, set `grp_idx=0`, go to FETCH.
- FETCH:
  - `in_ready=1`.
  - On handshake, register `dec_data_in=in_word` and `dec_control_word_in=cw[0]`, go to ISSUE.
- ISSUE:
  - When `dec_busy` is sampled 0, pulse `dec_data_in_valid` for exactly one cycle, go to WAIT_ACK.
- WAIT_ACK: wait for `dec_busy=1`, then go to WAIT_DONE.
- WAIT_DONE: on `dec_busy=0`:
  - Decrement `items_left`, shift `cw` right, increment `grp_idx`.
  - `items_left` reaches 0: go to FINISH.
  - Else `grp_idx` reaches 16: go to LOAD_CW.
  - Else: go to FETCH.
- FINISH: set `done`, go to IDLE.
- Control-word bit order is LSB-first: bit 0 describes the first item after the control word.
- A partial final group still consumes one control word; its unused bits are ignored.
- `dec_data_in` and `dec_control_word_in` are held stable from the FETCH handshake until WAIT_DONE exits.
- `byte_count` increments on every cycle with `dec_out_valid=1` while `sched_busy=1`.
- `start` is ignored while `sched_busy=1`.
- `in_valid=0` stalls in LOAD_CW/FETCH indefinitely; no timeout applies there.

## Timing
- Reset values:
  - State IDLE; all outputs 0.
  - Internal `items_left`, `cw` and `grp_idx` at 0.
- All outputs are registered except `in_ready`, which is decoded from state.
- `start` at edge N: `sched_busy=1` and `in_ready=1` from N+1.
- Minimum item cost: FETCH 1 + ISSUE 1 + WAIT_ACK ≥1 + WAIT_DONE ≥1 = 4 cycles, plus 1 cycle per control word.
- `done` rises 1 cycle after the final WAIT_DONE exit. `sched_busy` falls in the same cycle.
- `reset` mid-job: immediate return to IDLE with all outputs 0. The upstream stream position is lost; the source must also be reset.

## Configuration
- `LZRW1_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT_ACK and WAIT_DONE and clears on each state entry.
  - When it reaches `TIMEOUT_CYCLES`, set `error=1` and `done=1` and go to IDLE.
- Undefined: no counter, `error` tied to 0, and waits are unbounded.

## Structure
- `lzrw1_pkg` holds:
  - the state enum `sched_state_t`;
  - `GROUP_SIZE=16`;
  - `WORD_W=16`.
  These are shared with `decompressor_top` and the benches.
- Sub-module `lzrw1_cw_unpacker` holds the 16-bit control-word shift register and the 4-bit group index. It has inputs load, shift, and word, and outputs `cur_bit` and `group_end`.

## Test plan
- Bench model: the decompressor responds with `busy` high 1 cycle after valid, for 3 cycles.
- Single literal:
  - Stimulus: `num_items=1`, stream 16'h0000, 16'h0041.
  - Response: one valid pulse with data 16'h0041 and control 0; `done` set; `byte_count` equals the model's `out_valid` pulses.
- Full group plus one item:
  - Stimulus: `num_items=17`, control words 16'hAAAA then 16'h0001.
  - Response: control pattern 0,1,0,1,… across items 0–15; item 16 has control 1; exactly 2 control words consumed.
- `num_items=0` → `done=1` 2 cycles after `start`; no `in_ready`, no valid pulse.
- Upstream stall:
  - Stimulus: `in_valid` low for 10 cycles during FETCH.
  - Response: no valid pulse during the stall; the stream is issued intact afterwards.
- Reset mid-job:
  - Stimulus: assert `reset` in WAIT_DONE.
  - Response: all outputs 0 next cycle; a new job completes normally.
- Watchdog (macro defined, `TIMEOUT_CYCLES=16`):
  - Stimulus: `dec_busy` stuck high.
  - Response: `error=1` and `done=1` 16 cycles after WAIT_ACK exit.

Source files
------------

// File: rtl/lzrw1_decomp_sched_pkg.sv
// Shared definitions for the LZRW1 decompression scheduler and its neighbours:
// sequencer state encoding, stream word width and control-word group size.
package lzrw1_pkg;

  localparam int WORD_W     = 16;
  localparam int GROUP_SIZE = 16;
  localparam int GRP_W      = $clog2(GROUP_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CW,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FINISH
  } sched_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    logic [WORD_W-1:0] r;
    r = (&v) ? v : v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/lzrw1_decomp_sched_if.sv
// Bundle of the job-control, upstream stream, decompressor handshake and
// status signals of the LZRW1 scheduler. master = scheduler, slave = its
// environment (job controller, stream source, decompressor).
interface lzrw1_decomp_sched_if #(
  parameter int CNT_W = 13
);
  import lzrw1_pkg::*;

  logic               start;
  logic [CNT_W-1:0]   num_items;
  logic [WORD_W-1:0]  in_word;
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  dec_data_in;
  logic               dec_control_word_in;
  logic               dec_data_in_valid;
  logic               dec_busy;
  logic               dec_out_valid;
  logic [WORD_W-1:0]  byte_count;
  logic               sched_busy;
  logic               done;
  logic               error;

  modport master (
    input  start, num_items, in_word, in_valid, dec_busy, dec_out_valid,
    output in_ready, dec_data_in, dec_control_word_in, dec_data_in_valid,
           byte_count, sched_busy, done, error
  );

  modport slave (
    output start, num_items, in_word, in_valid, dec_busy, dec_out_valid,
    input  in_ready, dec_data_in, dec_control_word_in, dec_data_in_valid,
           byte_count, sched_busy, done, error
  );

endinterface

// File: rtl/lzrw1_decomp_sched_cw_unpacker.sv
// Control-word unpacker: holds the current 16-bit control word and the index
// of the item within its group. Bits are consumed LSB-first; group_end flags
// that the item now being retired is the last one covered by this word.
module lzrw1_cw_unpacker
  import lzrw1_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic              cur_bit,
  output logic              group_end
);

  logic [WORD_W-1:0] cw_q, cw_d;
  logic [GRP_W-1:0]  grp_idx_q, grp_idx_d;

  // Load a fresh control word, or step to the next item's bit.
  always_comb begin
    cw_d      = cw_q;
    grp_idx_d = grp_idx_q;
    if (load) begin
      cw_d      = word;
      grp_idx_d = '0;
    end else if (shift) begin
      cw_d      = {1'b0, cw_q[WORD_W-1:1]};
      grp_idx_d = grp_idx_q + 1'b1;
    end
  end

  // Shift register and group index storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cw_q      <= '0;
      grp_idx_q <= '0;
    end else begin
      cw_q      <= cw_d;
      grp_idx_q <= grp_idx_d;
    end
  end

  assign cur_bit   = cw_q[0];
  assign group_end = (grp_idx_q == GRP_W'(GROUP_SIZE - 1));

endmodule

// File: rtl/lzrw1_decomp_sched.sv
// LZRW1 decompression scheduler: pulls a control word and up to 16 items per
// group from the upstream stream, issues items one at a time to the
// decompressor under its busy handshake, counts output bytes and flags done.
// Optional busy watchdog: define LZRW1_SCHED_TIMEOUT_EN.
module lzrw1_decomp_sched
  import lzrw1_pkg::*;
#(
  parameter int MAX_ITEMS      = 4096,
  parameter int CNT_W          = $clog2(MAX_ITEMS + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  lzrw1_decomp_sched_if.master bus
);

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  items_left_q, items_left_d;
  logic [WORD_W-1:0] byte_count_q, byte_count_d;
  logic [WORD_W-1:0] dec_data_q, dec_data_d;
  logic              dec_ctrl_q, dec_ctrl_d;
  logic              dec_valid_q, dec_valid_d;
  logic              sched_busy_q, sched_busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic cw_load, cw_shift, cur_bit, group_end;

  lzrw1_cw_unpacker u_unpacker (
    .clock     (clock),
    .reset     (reset),
    .load      (cw_load),
    .shift     (cw_shift),
    .word      (bus.in_word),
    .cur_bit   (cur_bit),
    .group_end (group_end)
  );

`ifdef LZRW1_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`else
  // Watchdog limit has no effect without the watchdog.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state, datapath and status decode for the sequencer.
  always_comb begin
    state_d      = state_q;
    items_left_d = items_left_q;
    byte_count_d = byte_count_q;
    dec_data_d   = dec_data_q;
    dec_ctrl_d   = dec_ctrl_q;
    dec_valid_d  = 1'b0;
    sched_busy_d = sched_busy_q;
    done_d       = done_q;
    error_d      = error_q;
    cw_load      = 1'b0;
    cw_shift     = 1'b0;

    if (sched_busy_q && bus.dec_out_valid) begin
      byte_count_d = sat_inc(byte_count_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          byte_count_d = '0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          sched_busy_d = 1'b1;
          if (bus.num_items == '0) begin
            state_d = ST_FINISH;
          end else begin
            items_left_d = bus.num_items;
            state_d      = ST_LOAD_CW;
          end
        end
      end
      ST_LOAD_CW: begin
        if (bus.in_valid) begin
          cw_load = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.in_valid) begin
          dec_data_d = bus.in_word;
          dec_ctrl_d = cur_bit;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.dec_busy) begin
          dec_valid_d = 1'b1;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.dec_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.dec_busy) begin
          items_left_d = items_left_q - 1'b1;
          cw_shift     = 1'b1;
          if (items_left_q == CNT_W'(1)) begin
            state_d = ST_FINISH;
          end else if (group_end) begin
            state_d = ST_LOAD_CW;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        done_d       = 1'b1;
        sched_busy_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef LZRW1_SCHED_TIMEOUT_EN
    // The counter restarts whenever the wait states are entered or left, so
    // only an uninterrupted stay in WAIT_ACK or WAIT_DONE can trip it.
    wd_d = '0;
    if ((state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) && state_d == state_q) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        error_d      = 1'b1;
        done_d       = 1'b1;
        sched_busy_d = 1'b0;
        state_d      = ST_IDLE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      items_left_q <= '0;
      byte_count_q <= '0;
      dec_data_q   <= '0;
      dec_ctrl_q   <= 1'b0;
      dec_valid_q  <= 1'b0;
      sched_busy_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      items_left_q <= items_left_d;
      byte_count_q <= byte_count_d;
      dec_data_q   <= dec_data_d;
      dec_ctrl_q   <= dec_ctrl_d;
      dec_valid_q  <= dec_valid_d;
      sched_busy_q <= sched_busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

`ifdef LZRW1_SCHED_TIMEOUT_EN
  // Busy watchdog counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign bus.in_ready            = (state_q == ST_LOAD_CW) || (state_q == ST_FETCH);
  assign bus.dec_data_in         = dec_data_q;
  assign bus.dec_control_word_in = dec_ctrl_q;
  assign bus.dec_data_in_valid   = dec_valid_q;
  assign bus.byte_count          = byte_count_q;
  assign bus.sched_busy          = sched_busy_q;
  assign bus.done                = done_q;
  assign bus.error               = error_q;

endmodule

// File: tb/tb_lzrw1_decomp_sched.sv
// Directed bench for lzrw1_decomp_sched with a small decompressor model:
// busy rises one cycle after a valid pulse and stays high for 3 cycles; a
// literal emits 1 byte, a copy item emits 3 bytes.
// The watchdog step runs only when LZRW1_SCHED_TIMEOUT_EN is defined.
module tb_lzrw1_decomp_sched;
  import lzrw1_pkg::*;

  localparam int CNT_W = 13;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lzrw1_decomp_sched_if #(.CNT_W(CNT_W)) bus ();

  lzrw1_decomp_sched #(
    .MAX_ITEMS      (4096),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] src_q[$];
  logic [15:0] iss_data[$];
  logic        iss_ctrl[$];
  int          words_consumed = 0;
  bit          hs_last  = 1'b0;
  bit          pend     = 1'b0;
  int          busy_cnt = 0;
  bit          cur_copy = 1'b0;
  bit          stuck    = 1'b0;

  // Stream source and decompressor model, all driven on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      hs_last           = 1'b0;
      pend              = 1'b0;
      busy_cnt          = 0;
      bus.dec_busy      = 1'b0;
      bus.dec_out_valid = 1'b0;
      bus.in_valid      = 1'b0;
      bus.in_word       = 16'h0;
    end else begin
      if (hs_last) begin
        void'(src_q.pop_front());
        words_consumed++;
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.dec_busy      = 1'b0;
          bus.dec_out_valid = 1'b0;
        end else begin
          bus.dec_out_valid = cur_copy;
        end
      end else if (pend) begin
        pend              = 1'b0;
        bus.dec_busy      = 1'b1;
        bus.dec_out_valid = 1'b1;
        busy_cnt          = 3;
      end
      if (stuck) bus.dec_busy = 1'b1;
      if (bus.dec_data_in_valid) begin
        pend     = 1'b1;
        cur_copy = bus.dec_control_word_in;
        iss_data.push_back(bus.dec_data_in);
        iss_ctrl.push_back(bus.dec_control_word_in);
      end
      bus.in_valid = (src_q.size() > 0);
      bus.in_word  = (src_q.size() > 0) ? src_q[0] : 16'h0;
      hs_last      = bus.in_valid && bus.in_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int n);
    @(negedge clock);
    bus.num_items = CNT_W'(n);
    bus.start     = 1'b1;
    @(negedge clock);
    bus.start     = 1'b0;
    chk("start_busy", bus.sched_busy, 1);
    chk("start_done_clr", bus.done, 0);
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    while (!bus.done && i < bound) begin
      @(negedge clock);
      i++;
    end
    chk("done_reached", bus.done, 1);
  endtask

  task automatic clear_log();
    iss_data.delete();
    iss_ctrl.delete();
    words_consumed = 0;
  endtask

  task automatic chk_item(input int idx, input logic [15:0] d, input logic c);
    if (idx < iss_data.size()) begin
      chk($sformatf("item%0d_data", idx), iss_data[idx], d);
      chk($sformatf("item%0d_ctrl", idx), iss_ctrl[idx], c);
    end else begin
      chk($sformatf("item%0d_present", idx), iss_data.size(), idx + 1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  bus.sched_busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_err"},   bus.error, 0);
    chk({tag, "_bytes"}, bus.byte_count, 0);
    chk({tag, "_data"},  bus.dec_data_in, 0);
    chk({tag, "_ctrl"},  bus.dec_control_word_in, 0);
    chk({tag, "_valid"}, bus.dec_data_in_valid, 0);
    chk({tag, "_rdy"},   bus.in_ready, 0);
  endtask

  initial begin
    int n0;
    int i;
    bus.start     = 1'b0;
    bus.num_items = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clock);
    chk_all_zero("post_rst");
    $display("step reset: outputs checked");

    // Single literal
    clear_log();
    src_q.push_back(16'h0000);
    src_q.push_back(16'h0041);
    start_job(1);
    chk("lit_in_ready", bus.in_ready, 1);
    wait_done(200);
    chk("lit_count", iss_data.size(), 1);
    chk_item(0, 16'h0041, 1'b0);
    chk("lit_bytes", bus.byte_count, 1);
    chk("lit_busy_end", bus.sched_busy, 0);
    chk("lit_words", words_consumed, 2);
    chk("lit_err", bus.error, 0);
    $display("step single literal: items=%0d bytes=%0d", iss_data.size(), bus.byte_count);

    // Full group plus one item
    clear_log();
    src_q.push_back(16'hAAAA);
    for (int k = 0; k < 16; k++) src_q.push_back(16'h0100 + 16'(k));
    src_q.push_back(16'h0001);
    src_q.push_back(16'h0110);
    start_job(17);
    wait_done(2000);
    chk("grp_count", iss_data.size(), 17);
    for (int k = 0; k < 17; k++) chk_item(k, 16'h0100 + 16'(k), (k < 16) ? k[0] : 1'b1);
    chk("grp_bytes", bus.byte_count, 35);
    chk("grp_words", words_consumed, 19);
    $display("step group+1: items=%0d bytes=%0d words=%0d", iss_data.size(), bus.byte_count, words_consumed);

    // Zero items
    n0 = iss_data.size();
    start_job(0);
    chk("zero_rdy0", bus.in_ready, 0);
    @(negedge clock);
    chk("zero_done", bus.done, 1);
    chk("zero_busy", bus.sched_busy, 0);
    chk("zero_rdy1", bus.in_ready, 0);
    chk("zero_bytes", bus.byte_count, 0);
    chk("zero_noissue", iss_data.size(), n0);
    $display("step zero items: done=%0d", bus.done);

    // Upstream stall in FETCH
    clear_log();
    src_q.push_back(16'h0002);
    start_job(3);
    i = 0;
    while (words_consumed < 1 && i < 50) begin
      @(negedge clock);
      i++;
    end
    chk("stall_cw_taken", words_consumed, 1);
    repeat (10) @(negedge clock);
    chk("stall_noissue", iss_data.size(), 0);
    chk("stall_rdy", bus.in_ready, 1);
    src_q.push_back(16'h0201);
    src_q.push_back(16'h0202);
    src_q.push_back(16'h0203);
    wait_done(500);
    chk("stall_count", iss_data.size(), 3);
    chk_item(0, 16'h0201, 1'b0);
    chk_item(1, 16'h0202, 1'b1);
    chk_item(2, 16'h0203, 1'b0);
    chk("stall_bytes", bus.byte_count, 5);
    chk("stall_words", words_consumed, 4);
    $display("step stall: items=%0d bytes=%0d", iss_data.size(), bus.byte_count);

    // Reset in WAIT_DONE
    clear_log();
    src_q.push_back(16'h0000);
    src_q.push_back(16'h0301);
    src_q.push_back(16'h0302);
    start_job(2);
    i = 0;
    while (!bus.dec_busy && i < 50) begin
      @(negedge clock);
      i++;
    end
    chk("mid_busy_seen", bus.dec_busy, 1);
    @(negedge clock);
    chk("mid_data_held", bus.dec_data_in, 16'h0301);
    reset = 1'b1;
    src_q.delete();
    @(negedge clock);
    chk_all_zero("mid_rst");
    clear_log();
    reset = 1'b0;
    src_q.push_back(16'h0004);
    src_q.push_back(16'h0401);
    src_q.push_back(16'h0402);
    src_q.push_back(16'h0403);
    start_job(3);
    wait_done(500);
    chk("rejob_count", iss_data.size(), 3);
    chk_item(0, 16'h0401, 1'b0);
    chk_item(1, 16'h0402, 1'b0);
    chk_item(2, 16'h0403, 1'b1);
    chk("rejob_bytes", bus.byte_count, 5);
    chk("rejob_err", bus.error, 0);
    $display("step reset mid-job: new job items=%0d bytes=%0d", iss_data.size(), bus.byte_count);

`ifdef LZRW1_SCHED_TIMEOUT_EN
    // Watchdog with busy stuck high
    clear_log();
    src_q.push_back(16'h0000);
    src_q.push_back(16'h0501);
    start_job(1);
    i = 0;
    while (iss_data.size() < 1 && i < 50) begin
      @(negedge clock);
      i++;
    end
    stuck = 1'b1;
    repeat (10) @(negedge clock);
    chk("wd_not_early", bus.error, 0);
    i = 0;
    while (!bus.error && i < 30) begin
      @(negedge clock);
      i++;
    end
    chk("wd_error", bus.error, 1);
    chk("wd_done", bus.done, 1);
    chk("wd_busy", bus.sched_busy, 0);
    $display("step watchdog: error=%0d done=%0d", bus.error, bus.done);
    stuck = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
